// File: rtl/scr1_ahb_pkg.sv
// Shared AHB-Lite encodings and the RAM slave FSM state type.
package scr1_ahb_pkg;

    localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] SCR1_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] SCR1_HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] SCR1_HSIZE_8B  = 3'd0;
    localparam logic [2:0] SCR1_HSIZE_16B = 3'd1;
    localparam logic [2:0] SCR1_HSIZE_32B = 3'd2;

    localparam logic SCR1_HRESP_OKAY  = 1'b0;
    localparam logic SCR1_HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        SCR1_AHB_SLV_IDLE = 2'd0,
        SCR1_AHB_SLV_WAIT = 2'd1,
        SCR1_AHB_SLV_ERR1 = 2'd2,
        SCR1_AHB_SLV_ERR2 = 2'd3
    } type_scr1_ahb_slv_fsm_e;

    // IDLE and BUSY carry no transfer; NONSEQ and SEQ do.
    function automatic logic scr1_ahb_trans_active(input logic [1:0] htrans);
        return !((htrans == SCR1_HTRANS_IDLE) || (htrans == SCR1_HTRANS_BUSY));
    endfunction

    // Byte lanes touched by a transfer of the given size at the given low address bits.
    function automatic logic [3:0] scr1_ahb_byte_en(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case ({1'b0, size})
            SCR1_HSIZE_8B:  be = 4'b0001 << a;
            SCR1_HSIZE_16B: be = 4'b0011 << a;
            default:        be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/scr1_ahb_ram_slave_mem.sv
// Word-organised RAM with per-byte write enables and asynchronous read.
module scr1_ahb_ram_slave_mem #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned AW        = 10
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [MEM_WORDS];

    // Write only the enabled byte lanes of the addressed word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/scr1_ahb_ram_slave.sv
// AHB-Lite RAM responder: address decode, error detection, wait-state FSM.
module scr1_ahb_ram_slave
    import scr1_ahb_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic [31:0] haddr,
    input  logic [2:0]  hsize,
    input  logic        hwrite,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;
    localparam logic [3:0]  WS_LOAD   = 4'(WAIT_STATES);

    // Handshake: an address phase is taken on a rising edge with
    // hsel & hready & (NONSEQ|SEQ) while the slave is able to accept; its data
    // phase completes on the first later edge where hreadyout=1. A new address
    // may be taken on that same completing edge.

    type_scr1_ahb_slv_fsm_e state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic          write_q, write_d;
    logic          pend_q, pend_d;

    logic          accept_en;
    logic          accept;
    logic          addr_err;
    logic          complete;
    logic          mem_we;
    logic [31:0]   mem_rdata;

    // Transfer is rejected for illegal size, misalignment or out-of-range address.
    always_comb begin
        addr_err = 1'b0;
        if (hsize > SCR1_HSIZE_32B)                              addr_err = 1'b1;
        if ((hsize == SCR1_HSIZE_16B) && haddr[0])               addr_err = 1'b1;
        if ((hsize == SCR1_HSIZE_32B) && (haddr[1:0] != 2'b00))  addr_err = 1'b1;
        if ({1'b0, haddr} >= MEM_BYTES)                          addr_err = 1'b1;
    end

    // Next-state, wait counter, address latch and bus response outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        size_d    = size_q;
        write_d   = write_q;
        pend_d    = pend_q;
        hreadyout = 1'b1;
        hresp     = SCR1_HRESP_OKAY;
        accept_en = 1'b0;

        case (state_q)
            SCR1_AHB_SLV_IDLE: begin
                accept_en = 1'b1;
            end
            SCR1_AHB_SLV_WAIT: begin
                hreadyout = (cnt_q == 4'd0);
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    accept_en = 1'b1;
                end
            end
            SCR1_AHB_SLV_ERR1: begin
                hreadyout = 1'b0;
                hresp     = SCR1_HRESP_ERROR;
                state_d   = SCR1_AHB_SLV_ERR2;
            end
            SCR1_AHB_SLV_ERR2: begin
                hresp     = SCR1_HRESP_ERROR;
                accept_en = 1'b1;
            end
            default: begin
                state_d = SCR1_AHB_SLV_IDLE;
            end
        endcase

        accept = accept_en & hsel & hready & scr1_ahb_trans_active(htrans);

        if (accept_en) begin
            state_d = SCR1_AHB_SLV_IDLE;
            pend_d  = 1'b0;
            if (accept) begin
                addr_d  = haddr[AW+1:0];
                size_d  = hsize[1:0];
                write_d = hwrite;
                if (addr_err) begin
                    state_d = SCR1_AHB_SLV_ERR1;
                end else begin
                    pend_d = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_d = SCR1_AHB_SLV_WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end
            end
        end
    end

    // State register; RAM contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCR1_AHB_SLV_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            size_q  <= 2'd0;
            write_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            pend_q  <= pend_d;
        end
    end

    // A pending OKAY transfer finishes in the cycle the slave is ready.
    assign complete = pend_q & hreadyout;
    assign mem_we   = complete & write_q & ~rst;
    assign hrdata   = (complete & ~write_q) ? mem_rdata : 32'h0;

    scr1_ahb_ram_slave_mem #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .be_i    (scr1_ahb_byte_en(size_q, addr_q[1:0])),
        .addr_i  (addr_q[AW+1:2]),
        .wdata_i (hwdata),
        .rdata_o (mem_rdata)
    );

endmodule

// File: doc/scr1_ahb_ram_slave.md
Name: scr1_ahb_ram_slave

Overview:
- AHB-Lite responder backed by an internal word-organised RAM array.
- It is the target end of the AHB interface the core's memory bridges drive, and serves both instruction fetches and data accesses in simulation/FPGA tops.
- Configurable wait states; OKAY/ERROR two-cycle responses.
- Byte/halfword/word writes via hsize and haddr[1:0].

Parameters:
- MEM_WORDS, 1024: RAM depth in 32-bit words; the valid byte range is 0 .. MEM_WORDS*4-1.
- WAIT_STATES, 0: hreadyout-low cycles inserted in each OKAY data phase (0..15).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- hsel  in  1  slave select.
- htrans  in  2  transfer type; IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- haddr  in  32  byte address.
- hsize  in  3  0=byte, 1=half, 2=word.
- hwrite  in  1  1=write.
- hwdata  in  32  write data, valid in the data phase.
- hready  in  1  bus-level ready (hreadyin).
- hreadyout  out  1  slave ready.
- hresp  out  1  0=OKAY, 1=ERROR.
- hrdata  out  32  read data.

Behaviour:
- Reset: state IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter=0. RAM contents are not reset.
- Address phase is accepted on an edge where hsel & hready & htrans[1]. On acceptance, latch haddr, hsize and hwrite.
- IDLE/BUSY or unselected transfers: no state change; the next cycle is zero-wait OKAY.
- Error check at acceptance. A transfer is an error if any of the following holds:
  - hsize>2
  - misaligned (half with haddr[0]=1; word with haddr[1:0]!=0)
  - haddr >= MEM_WORDS*4
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: accept good -> WAIT if WAIT_STATES>0, else stay in IDLE (zero-wait data phase). Accept bad -> ERR1.
  - WAIT: counter loaded with WAIT_STATES at acceptance and decremented each cycle; hreadyout=(cnt==0). On the cnt==0 cycle, the next state is decided by the accept condition exactly as in IDLE.
  - ERR1: hreadyout=0, hresp=1 -> ERR2.
  - ERR2: hreadyout=1, hresp=1. The master may issue a new address here; the accept rule is as in IDLE.
- Data phase completes on the cycle hreadyout=1 with an OKAY transfer pending.
  - Read: hrdata = RAM[latched addr>>2], full word, no lane shifting.
  - Write: commit on that clock edge. Byte enables come from the latched hsize/addr[1:0]: byte -> 1<<a[1:0]; half -> 3<<a[1:0]; word -> 4'hF. Only the enabled lanes of hwdata are written.
- hrdata=0 in every cycle that is not a completing read data phase.
- Errored writes never modify the RAM.
- Back-to-back write A then read A with zero wait states: the read data phase returns the newly written data (the write commits before the read's data cycle).
- Pipelining: a new address phase may overlap the final data cycle of the previous transfer. Acceptance in WAIT/ERR1 while hreadyout=0 is impossible, because hready=0 then.
- Reset mid-transfer: the FSM returns to IDLE and the pending write is dropped.

Decomposition:
- Package scr1_ahb_pkg (shared): HTRANS, HSIZE and HRESP constants, plus the slave FSM enum type_scr1_ahb_slv_fsm_e.
- One sub-module, scr1_ahb_ram_slave_mem: word array with 4-bit byte-enable write and asynchronous read.
- The FSM, wait counter and error decode stay in the top.

Test Plan:
- WAIT_STATES=0: word write 0x0000_0010 = 0xDEADBEEF, then NONSEQ read 0x10 back-to-back -> hreadyout stays 1 throughout; read data phase hrdata=0xDEADBEEF, hresp=0.
- WAIT_STATES=2: word read -> exactly 2 cycles of hreadyout=0, then hreadyout=1 with data, hresp=0.
- Byte write 0x55 at 0x13 over word 0x11223344 -> read 0x10 returns 0x55223344. Half write 0xAAAA at 0x10 -> read returns 0x5522AAAA.
- Out-of-range read at MEM_WORDS*4 and misaligned word at 0x2 -> ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1). A write to 0x2 leaves word 0 unchanged.
- hsel=0 or htrans=IDLE/BUSY with haddr=0x0 -> no transfer; hreadyout=1, hresp=0, RAM unchanged.
- Assert rst during WAIT of a pending write -> next cycle hreadyout=1, hresp=0, hrdata=0; the target word is unchanged.
